// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//
// Conditions the raw DE2 slide switches before the CPU reads them. Each bit
// passes through a two-flop synchroniser and then its own debounce counter.
// The synchronised bit must disagree with the stable value for DEBOUNCE_CYCLES
// consecutive clocks before the stable value follows it. Whenever a stable bit
// changes, a one-cycle rise or fall pulse is raised for that bit. The pulses
// also feed sticky event flags that software can poll and then clear.
//
// Ports:
//   clk          system clock; every flop updates on its rising edge
//   reset_n      synchronous, active-low reset
//   sw_raw       asynchronous switch pins [WIDTH-1:0]
//   evt_clear    one-cycle request to clear evt_pending / evt_bits
//   sw_stable    debounced switch word (CPU read data at address 60)
//   sw_rise      one-cycle pulse per bit on a stable 0->1 change
//   sw_fall      one-cycle pulse per bit on a stable 1->0 change
//   evt_pending  sticky: some stable bit changed since the last clear
//   evt_bits     sticky per-bit record of the changes since the last clear
//
// Handshake: there is no valid/ready pair. The pulses are plain one-cycle
// strobes, and the event flags are level outputs that stay set until
// evt_clear is sampled high on a rising edge. If a clear and a new change
// arrive on the same edge, the new change survives.
// -----------------------------------------------------------------------------
module sw_debounce #(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   input  logic             evt_clear,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             evt_pending,
   output logic [WIDTH-1:0] evt_bits
);

   // This is the count at which one more mismatching clock makes the change
   // final. The counter is cleared at that point, so it never wraps.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [CNT_W-1:0] cnt      [WIDTH];
   logic [CNT_W-1:0] cnt_nxt  [WIDTH];
   logic [WIDTH-1:0] stable_nxt;
   logic [WIDTH-1:0] rise_nxt;
   logic [WIDTH-1:0] fall_nxt;
   logic [WIDTH-1:0] evt_bits_nxt;

   // Per-bit debounce decision.
   always_comb begin
      cnt_nxt    = cnt;
      stable_nxt = sw_stable;
      rise_nxt   = '0;
      fall_nxt   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync2[i] == sw_stable[i]) begin
            // Agreement at any point discards a partial count. This is how
            // short glitches and bounces are rejected.
            cnt_nxt[i] = '0;
         end else if (cnt[i] == CNT_LAST) begin
            cnt_nxt[i]    = '0;
            stable_nxt[i] = sync2[i];
            // The pulse is registered on the same edge as the new stable
            // value, so the two become visible in the same cycle.
            rise_nxt[i]   = sync2[i];
            fall_nxt[i]   = ~sync2[i];
         end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
         end
      end
   end

   // The events use the pulses that are visible this cycle. A change present
   // now is ORed in after the clear is applied, so it is not lost.
   always_comb begin
      evt_bits_nxt = (evt_clear ? '0 : evt_bits) | sw_rise | sw_fall;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1       <= '0;
         sync2       <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
         sw_stable   <= '0;
         sw_rise     <= '0;
         sw_fall     <= '0;
         evt_bits    <= '0;
         evt_pending <= 1'b0;
      end else begin
         sync1       <= sw_raw;
         sync2       <= sync1;
         cnt         <= cnt_nxt;
         sw_stable   <= stable_nxt;
         sw_rise     <= rise_nxt;
         sw_fall     <= fall_nxt;
         evt_bits    <= evt_bits_nxt;
         evt_pending <= |evt_bits_nxt;
      end
   end

endmodule

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
//
// Directed bench for sw_debounce with DEBOUNCE_CYCLES = 4. Each stimulus step
// pushes the pulse it expects into exp_q, packed as
// {cycle, rise, fall, stable}. A separate monitor pops one entry on every
// cycle in which the DUT shows a rise or fall pulse. A pulse that arrives
// with no entry waiting, or an entry left over at the end, is counted as a
// failure. Level outputs such as the reset state and the event flags are
// checked directly by the driver.
//
// Timing: inputs change and outputs are sampled on the falling edge. cyc
// counts rising edges. An input driven when cyc == c is first sampled on
// edge c+1, so a change that is held produces its pulse at cyc == c+6.
// -----------------------------------------------------------------------------
module tb_sw_debounce;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int EW = 32 + 3 * W;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] sw_raw;
   logic         evt_clear;
   logic [W-1:0] sw_stable;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         evt_pending;
   logic [W-1:0] evt_bits;

   int           cyc     = 0;
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [EW-1:0] exp_q[$];

   sw_debounce #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sw_raw      (sw_raw),
      .evt_clear   (evt_clear),
      .sw_stable   (sw_stable),
      .sw_rise     (sw_rise),
      .sw_fall     (sw_fall),
      .evt_pending (evt_pending),
      .evt_bits    (evt_bits)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Expect a pulse D+2 cycles after the input driven in this cycle.
   task automatic expect_pulse(input logic [W-1:0] rise, input logic [W-1:0] fall,
                               input logic [W-1:0] stable);
      exp_q.push_back({32'(cyc + D + 2), rise, fall, stable});
   endtask

   task automatic check_evt(input string name, input logic pend,
                            input logic [W-1:0] bits);
      check({name, "_pending"}, 32'(evt_pending), 32'(pend));
      check({name, "_bits"}, 32'(evt_bits), 32'(bits));
   endtask

   task automatic clear_evt();
      evt_clear = 1'b1;
      tick(1);
      evt_clear = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (reset_n === 1'b1 && (sw_rise | sw_fall) != '0) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: cyc %0d rise %h fall %h stable %h, none expected",
                     cyc, sw_rise, sw_fall, sw_stable);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            if ({32'(cyc), sw_rise, sw_fall, sw_stable} !== e) begin
               n_fail++;
               $display("FAIL pulse: got cyc %0d rise %h fall %h stable %h, expected cyc %0d rise %h fall %h stable %h",
                        cyc, sw_rise, sw_fall, sw_stable,
                        e[EW-1 -: 32], e[3*W-1 -: W], e[2*W-1 -: W], e[W-1:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset_n   = 1'b0;
      sw_raw    = 16'hFFFF;
      evt_clear = 1'b0;

      // Reset for 2 clocks while all switches are high.
      tick(2);
      check("rst_stable", 32'(sw_stable), 32'h0);
      check("rst_rise", 32'(sw_rise), 32'h0);
      check("rst_fall", 32'(sw_fall), 32'h0);
      check_evt("rst", 1'b0, 16'h0000);

      // Switches that are high at release rise D+2 clocks later.
      reset_n = 1'b1;
      expect_pulse(16'hFFFF, 16'h0000, 16'hFFFF);
      tick(5);
      check("rel_not_yet", 32'(sw_stable), 32'h0);
      tick(2);
      check_evt("rel", 1'b1, 16'hFFFF);
      clear_evt();
      check_evt("rel_clr", 1'b0, 16'h0000);

      // All switches return low.
      sw_raw = 16'h0000;
      expect_pulse(16'h0000, 16'hFFFF, 16'h0000);
      tick(8);
      clear_evt();
      check_evt("fall_clr", 1'b0, 16'h0000);

      // Glitch: high for 3 clocks reaches cnt=3 and must then be discarded.
      sw_raw = 16'h0008;
      tick(3);
      sw_raw = 16'h0000;
      tick(10);
      check("glitch_stable", 32'(sw_stable), 32'h0);
      check_evt("glitch", 1'b0, 16'h0000);

      // Clean rise and fall on bit 0.
      sw_raw = 16'h0001;
      expect_pulse(16'h0001, 16'h0000, 16'h0001);
      tick(7);
      check("clean_stable", 32'(sw_stable), 32'h1);
      sw_raw = 16'h0000;
      expect_pulse(16'h0000, 16'h0001, 16'h0000);
      tick(8);
      check_evt("clean", 1'b1, 16'h0001);

      // Clear race: clear is sampled on the same edge that sees the rise[2] pulse.
      sw_raw = 16'h0004;
      expect_pulse(16'h0004, 16'h0000, 16'h0004);
      tick(6);
      clear_evt();
      check_evt("race", 1'b1, 16'h0004);
      clear_evt();
      check_evt("race_clr", 1'b0, 16'h0000);
      clear_evt();
      check_evt("noop_clr", 1'b0, 16'h0000);

      // Bounce on bit 5: five toggles 2 clocks apart, ending high.
      for (int k = 0; k < 5; k++) begin
         sw_raw[5] = ~sw_raw[5];
         if (k == 4) expect_pulse(16'h0020, 16'h0000, 16'h0024);
         tick(2);
      end
      tick(6);
      check_evt("bounce", 1'b1, 16'h0020);
      clear_evt();

      // Reset while cnt[7] == 3: partial count discarded, no pulse.
      sw_raw[7] = 1'b1;
      tick(5);
      reset_n = 1'b0;
      tick(1);
      check("midrst_stable", 32'(sw_stable), 32'h0);
      check_evt("midrst", 1'b0, 16'h0000);
      reset_n = 1'b1;
      expect_pulse(16'h00A4, 16'h0000, 16'h00A4);
      tick(10);
      check("final_stable", 32'(sw_stable), 32'h00A4);

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_pulse: %0d expected pulses never seen, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
